// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline boundary with a 2-entry skid buffer.
// The main register drives the memory stage. The skid register catches one
// entry that arrives while main is stalled. in_ready is registered, so
// out_ready never reaches in_ready through combinational logic.
// Branch resolution (ctl_branch & alu_zero) is evaluated at capture time.
module ex_mem_skid #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero,
   input  logic [DATA_W-1:0] store_data,
   input  logic [REG_AW-1:0] dest_reg,
   input  logic              ctl_mem_read,
   input  logic              ctl_mem_write,
   input  logic              ctl_reg_write,
   input  logic              ctl_branch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [DATA_W-1:0] out_store_data,
   output logic [REG_AW-1:0] out_dest_reg,
   output logic              out_mem_read,
   output logic              out_mem_write,
   output logic              out_reg_write,
   output logic              out_branch_taken
);

   // Entry layout: {result, store_data, dest_reg, mem_read, mem_write, reg_write, branch_taken}.
   // The four control bits sit at the bottom so a flush can clear them as one slice.
   localparam int ENTRY_W = 2*DATA_W + REG_AW + 4;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   state_t               state_reg, state_next;
   logic                 in_ready_reg;
   logic [ENTRY_W-1:0]   main_reg;
   logic [ENTRY_W-1:0]   skid_reg;
   logic [ENTRY_W-1:0]   in_entry;
   logic                 accept;
   logic                 drain;
   logic                 load_main_in;
   logic                 load_main_skid;
   logic                 load_skid;

   assign in_entry = {alu_result, store_data, dest_reg,
                      ctl_mem_read, ctl_mem_write, ctl_reg_write,
                      ctl_branch & alu_zero};

   assign accept = in_valid & in_ready_reg;
   assign drain  = out_valid & out_ready;

   // State register plus the registered ready flag, which looks ahead at the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= EMPTY;
         in_ready_reg <= 1'b1;
      end else begin
         state_reg    <= state_next;
         in_ready_reg <= (state_next != TWO);
      end
   end

   // Next-state and load-enable decode; flush overrides every other transition.
   always_comb begin
      state_next     = state_reg;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_next   = ONE;
            end
         end
         ONE: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid  = 1'b1;
               state_next = TWO;
            end else if (drain) begin
               state_next = EMPTY;
            end
         end
         TWO: begin
            if (drain) begin
               load_main_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
      if (flush) begin
         state_next     = EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   // Entry storage; a flush zeroes control bits but leaves the data fields alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_reg <= '0;
         skid_reg <= '0;
      end else if (flush) begin
         main_reg[3:0] <= 4'b0000;
         skid_reg[3:0] <= 4'b0000;
      end else begin
         if (load_main_in) begin
            main_reg <= in_entry;
         end else if (load_main_skid) begin
            main_reg <= skid_reg;
         end
         if (load_skid) begin
            skid_reg <= in_entry;
         end
      end
   end

   assign in_ready         = in_ready_reg;
   assign out_valid        = (state_reg != EMPTY);
   assign out_result       = main_reg[ENTRY_W-1 -: DATA_W];
   assign out_store_data   = main_reg[ENTRY_W-DATA_W-1 -: DATA_W];
   assign out_dest_reg     = main_reg[REG_AW+3 -: REG_AW];
   assign out_mem_read     = main_reg[3];
   assign out_mem_write    = main_reg[2];
   assign out_reg_write    = main_reg[1];
   assign out_branch_taken = main_reg[0];

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed testbench for ex_mem_skid: one task per scenario, inline checks.
module tb_ex_mem_skid;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] alu_result;
   logic        alu_zero;
   logic [15:0] store_data;
   logic [2:0]  dest_reg;
   logic        ctl_mem_read;
   logic        ctl_mem_write;
   logic        ctl_reg_write;
   logic        ctl_branch;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic [15:0] out_store_data;
   logic [2:0]  out_dest_reg;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        out_reg_write;
   logic        out_branch_taken;

   int checks;
   int failures;

   ex_mem_skid #(.DATA_W(16), .REG_AW(3)) dut (
      .clk              (clk),
      .rst              (rst),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .alu_result       (alu_result),
      .alu_zero         (alu_zero),
      .store_data       (store_data),
      .dest_reg         (dest_reg),
      .ctl_mem_read     (ctl_mem_read),
      .ctl_mem_write    (ctl_mem_write),
      .ctl_reg_write    (ctl_reg_write),
      .ctl_branch       (ctl_branch),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_store_data   (out_store_data),
      .out_dest_reg     (out_dest_reg),
      .out_mem_read     (out_mem_read),
      .out_mem_write    (out_mem_write),
      .out_reg_write    (out_reg_write),
      .out_branch_taken (out_branch_taken)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one entry on the execute-side inputs.
   task automatic drive(input logic v, input logic [15:0] res, input logic [15:0] sd,
                        input logic [2:0] dr, input logic rd, input logic wr,
                        input logic rw, input logic br, input logic zero);
      in_valid      = v;
      alu_result    = res;
      store_data    = sd;
      dest_reg      = dr;
      ctl_mem_read  = rd;
      ctl_mem_write = wr;
      ctl_reg_write = rw;
      ctl_branch    = br;
      alu_zero      = zero;
   endtask

   task automatic idle();
      drive(1'b0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      idle();
      #12;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL reset_out_result got=%h exp=0000", out_result); end
      checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL reset_out_reg_write got=%b exp=0", out_reg_write); end
      $display("reset: out_valid=%b in_ready=%b", out_valid, in_ready);
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      drive(1'b1, 16'h1234, 16'hBEEF, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
      checks++; if (out_result !== 16'h1234) begin failures++; $display("FAIL basic_out_result got=%h exp=1234", out_result); end
      checks++; if (out_store_data !== 16'hBEEF) begin failures++; $display("FAIL basic_store_data got=%h exp=beef", out_store_data); end
      checks++; if (out_dest_reg !== 3'd5) begin failures++; $display("FAIL basic_dest_reg got=%0d exp=5", out_dest_reg); end
      checks++; if (out_reg_write !== 1'b1) begin failures++; $display("FAIL basic_reg_write got=%b exp=1", out_reg_write); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL basic_in_ready got=%b exp=1", in_ready); end
      $display("basic: out_result=%h dest=%0d", out_result, out_dest_reg);
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drained got=%b exp=0", out_valid); end
   endtask

   task automatic test_skid();
      out_ready = 1'b0;
      drive(1'b1, 16'h0001, 16'h0000, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      checks++; if (out_result !== 16'h0001) begin failures++; $display("FAIL skid_a_result got=%h exp=0001", out_result); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_one_in_ready got=%b exp=1", in_ready); end
      drive(1'b1, 16'h0002, 16'h0000, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      checks++; if (out_result !== 16'h0001) begin failures++; $display("FAIL skid_a_held got=%h exp=0001", out_result); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_two_in_ready got=%b exp=0", in_ready); end
      tick();
      checks++; if (out_result !== 16'h0001) begin failures++; $display("FAIL skid_stall_hold got=%h exp=0001", out_result); end
      checks++; if (out_dest_reg !== 3'd1) begin failures++; $display("FAIL skid_stall_dest got=%0d exp=1", out_dest_reg); end
      $display("skid: stalled out_result=%h in_ready=%b", out_result, in_ready);
      out_ready = 1'b1;
      tick();
      checks++; if (out_result !== 16'h0002) begin failures++; $display("FAIL skid_b_result got=%h exp=0002", out_result); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL skid_ready_back got=%b exp=1", in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL skid_b_valid got=%b exp=1", out_valid); end
      $display("skid: released out_result=%h in_ready=%b", out_result, in_ready);
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL skid_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      drive(1'b1, 16'h0100, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      alu_zero = 1'b0;
      checks++; if (out_branch_taken !== 1'b1) begin failures++; $display("FAIL branch_taken got=%b exp=1", out_branch_taken); end
      drive(1'b1, 16'h0101, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      checks++; if (out_branch_taken !== 1'b0) begin failures++; $display("FAIL branch_not_zero got=%b exp=0", out_branch_taken); end
      drive(1'b1, 16'h0102, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      idle();
      checks++; if (out_branch_taken !== 1'b0) begin failures++; $display("FAIL branch_no_ctl got=%b exp=0", out_branch_taken); end
      checks++; if (out_result !== 16'h0102) begin failures++; $display("FAIL branch_last_result got=%h exp=0102", out_result); end
      $display("branch: last out_branch_taken=%b", out_branch_taken);
      tick();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 16'h000A, 16'h1111, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h000B, 16'h2222, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_pre_two got=%b exp=0", in_ready); end
      checks++; if (out_mem_write !== 1'b1) begin failures++; $display("FAIL flush_pre_mem_write got=%b exp=1", out_mem_write); end
      flush = 1'b1;
      drive(1'b1, 16'h00FF, 16'h3333, 3'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      flush = 1'b0;
      idle();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_two_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_two_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_mem_write !== 1'b0) begin failures++; $display("FAIL flush_two_mem_write got=%b exp=0", out_mem_write); end
      out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_no_ghost got=%b exp=0", out_valid); end
      // Flush in ONE while in_ready=1: the concurrent entry must still be dropped.
      out_ready = 1'b0;
      drive(1'b1, 16'h000C, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      flush = 1'b1;
      drive(1'b1, 16'h00FF, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      flush = 1'b0;
      idle();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_one_drop got=%b exp=0", out_valid); end
      checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL flush_one_reg_write got=%b exp=0", out_reg_write); end
      checks++; if (out_mem_read !== 1'b0) begin failures++; $display("FAIL flush_one_mem_read got=%b exp=0", out_mem_read); end
      $display("flush: out_valid=%b in_ready=%b", out_valid, in_ready);
      tick();
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 16'h0010 + 16'(i), 16'h0000, 3'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
         tick();
         checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (out_result !== 16'h0010 + 16'(i)) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, out_result, 16'h0010 + 16'(i)); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); end
         $display("b2b: beat %0d out_result=%h", i, out_result);
      end
      idle();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b exp=0", out_valid); end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive(1'b1, 16'h0055, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      idle();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL areset_pre_valid got=%b exp=1", out_valid); end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready got=%b exp=1", in_ready); end
      checks++; if (out_result !== 16'h0000) begin failures++; $display("FAIL areset_out_result got=%h exp=0000", out_result); end
      checks++; if (out_reg_write !== 1'b0) begin failures++; $display("FAIL areset_reg_write got=%b exp=0", out_reg_write); end
      $display("async_reset: out_valid=%b in_ready=%b", out_valid, in_ready);
      #1;
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_after got=%b exp=0", out_valid); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      test_reset();
      test_basic();
      test_skid();
      test_branch();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Registered EX/MEM boundary stage that captures the ALU result, zero flag and execute-stage control bits every cycle.
- Presents them to the memory stage through a valid/ready handshake.
- A 2-entry skid buffer absorbs memory-stage back-pressure without a combinational ready path back into execute.
- Also resolves conditional branches: taken when the branch control bit is set and the ALU zero flag is 1.

Parameters:
DATA_W, 16, datapath width of ALU result and store data
REG_AW, 3, destination register index width (8-entry register file)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous kill of all buffered entries
in_valid  input  1  execute stage presents an entry
in_ready  output  1  stage can accept an entry this cycle (registered)
alu_result  input  DATA_W  ALU_out from the ALU
alu_zero  input  1  zero_flag from the ALU
store_data  input  DATA_W  rt operand for stores
dest_reg  input  REG_AW  writeback register index
ctl_mem_read  input  1  load
ctl_mem_write  input  1  store
ctl_reg_write  input  1  writeback enable
ctl_branch  input  1  conditional branch (beq)
out_valid  output  1  entry presented to memory stage
out_ready  input  1  memory stage accepts entry
out_result  output  DATA_W  buffered ALU result / memory address
out_store_data  output  DATA_W  buffered store data
out_dest_reg  output  REG_AW  buffered destination index
out_mem_read  output  1  buffered load flag
out_mem_write  output  1  buffered store flag
out_reg_write  output  1  buffered writeback enable
out_branch_taken  output  1  ctl_branch & alu_zero, captured at accept

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-high (rst).
- Reset values: out_valid=0, in_ready=1, all out_* data/control = 0, both entries empty.
- Storage: main register drives the out_* ports. The skid register holds one overflow entry.
- State, encoded by occupancy:
  - EMPTY: main empty, skid empty.
  - ONE: main full, skid empty.
  - TWO: main full, skid full.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- EMPTY:
  - accept -> load main, go to ONE.
  - no accept -> stay.
- ONE:
  - accept & drain -> load main with the new entry, stay.
  - accept & !drain -> load skid, go to TWO.
  - drain & !accept -> go to EMPTY.
  - neither -> hold.
- TWO:
  - drain -> move skid to main, go to ONE.
  - no drain -> hold.
  - in_ready=0 in TWO, so no accept is possible.
- in_ready is a register. It is 0 exactly when the next state is TWO and 1 otherwise. No combinational path from out_ready to in_ready.
- out_valid = (state != EMPTY), registered.
- Latency: an entry accepted in cycle N is visible on out_* in cycle N+1 when main was empty or drains in cycle N.
- Ordering: strict FIFO order. The skid entry always leaves before any later entry.
- out_branch_taken is computed at capture time and stored; it does not track a later alu_zero. It is 0 whenever ctl_branch=0.
- Data stability: out_* hold value while out_valid=1 & out_ready=0.
- Flush:
  - Synchronous; highest priority over accept and drain in the same cycle.
  - Next state EMPTY, out_valid=0, in_ready=1, out_* control bits forced 0. Data fields may hold their old value.
  - An in_valid entry presented in the flush cycle is dropped.
- Reset asserted mid-operation: immediate return to reset values regardless of state. Buffered entries are lost.
- Back-to-back: with out_ready held 1, one entry per cycle is sustained indefinitely.

Test Plan:
- Reset, then push alu_result=0x1234, store_data=0xBEEF, dest_reg=5, ctl_reg_write=1, out_ready=1 -> next cycle out_valid=1, out_result=0x1234, out_dest_reg=5, out_reg_write=1; in_ready stays 1.
- out_ready=0, push A=0x0001 then B=0x0002 -> out_result=0x0001 held, in_ready drops to 0 the cycle after B is accepted. Raise out_ready -> out_result 0x0001 then 0x0002 in consecutive cycles, in_ready returns to 1.
- ctl_branch=1, alu_zero=1 -> out_branch_taken=1. Next entry ctl_branch=1, alu_zero=0 -> out_branch_taken=0. ctl_branch=0, alu_zero=1 -> 0.
- In state TWO, assert flush together with in_valid=1 (result 0x00FF) -> next cycle out_valid=0, in_ready=1, out_mem_write=0; entry 0x00FF never appears.
- Stream 0x0010..0x001F with out_ready=1 every cycle -> 16 outputs on consecutive cycles, in order, no bubbles after the first.
- rst pulse asynchronously between clock edges while in state ONE -> out_valid=0 and in_ready=1 immediately, before the next clk edge.
